// File: rtl/ddr_queue_rd_engine.sv
// Turns {flag, queue, byte count} read requests into 4 KB-safe AXI4 read bursts over per-queue
// circular DDR regions and streams the data out. Optional rresp/rlast checking: RD_ENGINE_ERR_CHECK_EN.
`timescale 1ns/1ps
module ddr_queue_rd_engine #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 512,
  parameter int          P_DDR_LOCAL_QUEUE  = 4,
  parameter int          P_QUEUE_NUM        = 8,
  parameter int unsigned P_QUEUE_SIZE       = 32'h0008_0000,
  parameter int          P_MAX_BURST_LEN    = 64
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_rd_flag,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]              i_rd_queue,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]             i_rd_byte,
  input  logic                                      i_rd_byte_valid,
  output logic                                      o_rd_byte_ready,
  output logic                                      o_rd_queue_finish,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             o_m_axi_araddr,
  output logic [7:0]                                o_m_axi_arlen,
  output logic                                      o_m_axi_arvalid,
  input  logic                                      i_m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]             i_m_axi_rdata,
  input  logic [1:0]                                i_m_axi_rresp,
  input  logic                                      i_m_axi_rlast,
  input  logic                                      i_m_axi_rvalid,
  output logic                                      o_m_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]             o_axis_tdata,
  output logic                                      o_axis_tuser,
  output logic                                      o_axis_tlast,
  output logic                                      o_axis_tvalid,
  input  logic                                      i_axis_tready,
  output logic [P_QUEUE_NUM*C_M_AXI_ADDR_WIDTH-1:0] o_rd_ptr,
  output logic                                      o_rd_err
);
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int BPB = C_M_AXI_DATA_WIDTH / 8;
  localparam int SH  = $clog2(BPB);
  localparam int QW  = (P_QUEUE_NUM > 1) ? $clog2(P_QUEUE_NUM) : 1;
  localparam logic [AW-1:0] QSIZE = AW'(P_QUEUE_SIZE);
  localparam logic [AW-1:0] BPB_A = AW'(BPB);
  localparam logic [AW-1:0] MAXB  = AW'(P_MAX_BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_RDATA, S_FINISH} state_t;
  state_t state_reg, state_next;

  logic          flag_reg;
  logic [QW-1:0] queue_reg;
  logic [AW-1:0] beats_reg;
  logic [8:0]    burst_reg;
  logic [AW-1:0] araddr_reg;
  logic [7:0]    arlen_reg;
  logic [AW-1:0] queue_off [P_QUEUE_NUM];

  logic          accept, beat_fire, burst_end;
  logic [QW-1:0] queue_sel;
  logic [AW-1:0] req_beats, cur_off, calc_addr, to_end, to_4k, len;

  // Out-of-range queue indices fold onto the last region.
  always_comb begin
    if (32'(i_rd_queue) >= 32'(P_QUEUE_NUM)) queue_sel = QW'(P_QUEUE_NUM - 1);
    else                                     queue_sel = i_rd_queue[QW-1:0];
  end

  assign req_beats = (i_rd_byte >> SH) + AW'(|i_rd_byte[SH-1:0]);
  assign cur_off   = queue_off[queue_reg];
  assign calc_addr = AW'(queue_reg) * QSIZE + cur_off;
  assign to_end    = (QSIZE - cur_off) >> SH;
  assign to_4k     = (AW'(4096) - AW'(cur_off[11:0])) >> SH;

  always_comb begin
    len = beats_reg;
    if (MAXB < len)   len = MAXB;
    if (to_end < len) len = to_end;
    if (to_4k < len)  len = to_4k;
  end

  assign accept    = i_rd_byte_valid && o_rd_byte_ready;
  assign beat_fire = (state_reg == S_RDATA) && i_m_axi_rvalid && i_axis_tready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Zero-length requests still pass through CALC so every finish lands two cycles after accept.
  always_comb begin
    state_next        = state_reg;
    o_rd_byte_ready   = 1'b0;
    o_m_axi_arvalid   = 1'b0;
    o_m_axi_rready    = 1'b0;
    o_axis_tvalid     = 1'b0;
    o_axis_tlast      = 1'b0;
    o_axis_tdata      = '0;
    o_rd_queue_finish = 1'b0;
    case (state_reg)
      S_IDLE: begin
        o_rd_byte_ready = ~i_rst;
        if (i_rd_byte_valid && !i_rst) state_next = S_CALC;
      end
      S_CALC: state_next = (beats_reg == '0) ? S_FINISH : S_AR;
      S_AR: begin
        o_m_axi_arvalid = 1'b1;
        if (i_m_axi_arready) state_next = S_RDATA;
      end
      S_RDATA: begin
        o_m_axi_rready = i_axis_tready;
        o_axis_tvalid  = i_m_axi_rvalid;
        o_axis_tdata   = i_m_axi_rdata;
        o_axis_tlast   = i_m_axi_rvalid && (beats_reg == AW'(1));
        if (beat_fire && burst_end) state_next = (beats_reg == AW'(1)) ? S_FINISH : S_CALC;
      end
      S_FINISH: begin
        o_rd_queue_finish = 1'b1;
        state_next        = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flag_reg   <= 1'b0;
      queue_reg  <= '0;
      beats_reg  <= '0;
      burst_reg  <= '0;
      araddr_reg <= '0;
      arlen_reg  <= '0;
    end else begin
      if (accept) begin
        flag_reg  <= i_rd_flag;
        queue_reg <= queue_sel;
        beats_reg <= req_beats;
      end
      if (state_reg == S_CALC && beats_reg != '0) begin
        araddr_reg <= calc_addr;
        arlen_reg  <= 8'(len - AW'(1));
        burst_reg  <= 9'(len);
      end
      if (beat_fire) begin
        beats_reg <= beats_reg - AW'(1);
        burst_reg <= burst_reg - 9'd1;
      end
    end
  end

  for (genvar gi = 0; gi < P_QUEUE_NUM; gi++) begin : g_queue
    logic [AW-1:0] ptr_reg;
    always_ff @(posedge i_clk) begin
      if (i_rst) ptr_reg <= '0;
      else if (beat_fire && (queue_reg == QW'(gi))) ptr_reg <= (ptr_reg + BPB_A) & (QSIZE - AW'(1));
    end
    assign queue_off[gi]           = ptr_reg;
    assign o_rd_ptr[gi*AW +: AW]   = ptr_reg;
  end

`ifdef RD_ENGINE_ERR_CHECK_EN
  logic err_reg;
  // Burst length is trusted over rlast; a disagreeing rlast only raises the error flag.
  assign burst_end = (burst_reg == 9'd1);
  always_ff @(posedge i_clk) begin
    if (i_rst) err_reg <= 1'b0;
    else if (beat_fire && ((i_m_axi_rresp != 2'b00) || (i_m_axi_rlast != (burst_reg == 9'd1))))
      err_reg <= 1'b1;
  end
  assign o_rd_err = err_reg;
`else
  logic unused_sigs;
  assign burst_end   = i_m_axi_rlast;
  assign unused_sigs = &{1'b0, i_m_axi_rresp, burst_reg};
  assign o_rd_err    = 1'b0;
`endif

  assign o_m_axi_araddr = araddr_reg;
  assign o_m_axi_arlen  = arlen_reg;
  assign o_axis_tuser   = flag_reg;
endmodule

// File: tb/tb_ddr_queue_rd_engine.sv
// Randomized scoreboard bench for ddr_queue_rd_engine: a request-level reference model fills
// expectation queues, a monitor pops and compares on every AR / stream / finish handshake.
`timescale 1ns/1ps
module tb_ddr_queue_rd_engine;
  localparam int AW = 32, DW = 512, QN = 8, LQ = 4;
  localparam int QSIZE = 32'h0008_0000;
`ifdef RD_ENGINE_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic            rd_flag = 0, rd_valid = 0, rd_ready, finish;
  logic [LQ-1:0]   rd_queue = '0;
  logic [AW-1:0]   rd_byte = '0, araddr;
  logic [7:0]      arlen;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]   rdata, tdata;
  logic [1:0]      rresp;
  logic            tuser, tlast, tvalid, tready, rd_err;
  logic [QN*AW-1:0] rd_ptr;

  ddr_queue_rd_engine dut (
    .i_clk(clk), .i_rst(rst), .i_rd_flag(rd_flag), .i_rd_queue(rd_queue), .i_rd_byte(rd_byte),
    .i_rd_byte_valid(rd_valid), .o_rd_byte_ready(rd_ready), .o_rd_queue_finish(finish),
    .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen), .o_m_axi_arvalid(arvalid),
    .i_m_axi_arready(arready), .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp),
    .i_m_axi_rlast(rlast), .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready),
    .o_axis_tdata(tdata), .o_axis_tuser(tuser), .o_axis_tlast(tlast), .o_axis_tvalid(tvalid),
    .i_axis_tready(tready), .o_rd_ptr(rd_ptr), .o_rd_err(rd_err)
  );

  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DDR contents are a fixed function of the byte address.
  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = (a * 32'd2654435761) ^ (32'(k) << 20) ^ 32'h5A5A_0000;
    return d;
  endfunction

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [DW-1:0] data; logic last; logic user; } beat_t;
  typedef struct { bit zero; int acc; logic [QN*AW-1:0] ptr; } fin_t;
  ar_t   exp_ar[$], ar_log[$];
  beat_t exp_beat[$];
  fin_t  exp_fin[$];
  logic [31:0] model_off [QN];
  int cyc = 0, acc_cyc = 0, last_tlast_cyc = 0, beat_cnt = 0;
  bit first_ar_pending = 0, trdy_rand = 0, slv_fast = 0, err_en = 0;
  logic [31:0] err_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: split a request into bursts by the four length limits, one beat per 64 bytes.
  task automatic model_req(input int q, input logic [31:0] bytes, input bit flag, output bit zero);
    int qc; longint beats, off, n; ar_t a; beat_t b;
    qc = (q >= QN) ? QN - 1 : q;
    beats = (longint'(bytes) + 63) / 64;
    zero = (beats == 0);
    while (beats > 0) begin
      off = longint'(model_off[qc]);
      n = beats;
      if (n > 64) n = 64;
      if ((QSIZE - off) / 64 < n) n = (QSIZE - off) / 64;
      if ((4096 - off % 4096) / 64 < n) n = (4096 - off % 4096) / 64;
      a.addr = 32'(qc) * 32'(QSIZE) + 32'(off);
      a.len  = 8'(n - 1);
      exp_ar.push_back(a);
      for (longint i = 0; i < n; i++) begin
        b.data = pat(a.addr + 32'(i * 64));
        b.last = (beats - i == 1);
        b.user = flag;
        exp_beat.push_back(b);
      end
      model_off[qc] = 32'((off + n * 64) % QSIZE);
      beats -= n;
    end
  endtask

  task automatic flush_model();
    exp_ar.delete(); exp_beat.delete(); exp_fin.delete();
    for (int k = 0; k < QN; k++) model_off[k] = '0;
    first_ar_pending = 0;
  endtask

  task automatic issue(input int q, input logic [31:0] bytes, input bit flag);
    bit zero; fin_t f; int n;
    model_req(q, bytes, flag, zero);
    ar_log.delete(); beat_cnt = 0;
    rd_flag = flag; rd_queue = LQ'(q); rd_byte = bytes; rd_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_ready && n < 100);
    check("req_accepted", rd_ready, 1);
    acc_cyc = cyc; first_ar_pending = !zero;
    f.zero = zero; f.acc = cyc;
    for (int k = 0; k < QN; k++) f.ptr[k*AW +: AW] = model_off[k];
    exp_fin.push_back(f);
    @(posedge clk); #1 rd_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_fin.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check("req_done_in_budget", exp_fin.size() == 0, 1);
    if (exp_fin.size() != 0) begin
      @(posedge clk); #1 rst = 1; flush_model();
      repeat (3) @(posedge clk);
      #1 rst = 0;
    end
    @(posedge clk); #1;
  endtask

  // AXI read slave: random AR/R pacing, data from pat(), one burst at a time.
  initial begin
    bit active, arf, rf, rs; logic [31:0] baddr, cap_addr; int left, cap_len;
    active = 0; left = 0; baddr = '0;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 0;
    forever begin
      @(negedge clk);
      arf = arvalid && arready; rf = rvalid && rready; rs = rst;
      cap_addr = araddr; cap_len = int'(arlen);
      @(posedge clk); #1;
      if (rs) begin
        active = 0; left = 0; arready = 0; rvalid = 0; rlast = 0;
      end else begin
        if (arf) begin active = 1; baddr = cap_addr; left = cap_len + 1; end
        if (rf) begin baddr += 64; left--; if (left == 0) active = 0; end
        arready = !active && (slv_fast || $urandom_range(0, 3) != 0);
        if (!(rvalid && !rf)) rvalid = active && (slv_fast || $urandom_range(0, 3) != 0);
        rdata = pat(baddr);
        rlast = (left == 1);
        rresp = (err_en && baddr == err_addr) ? 2'd2 : 2'd0;
      end
    end
  end

  initial begin
    tready = 1;
    forever begin @(posedge clk); #1 tready = trdy_rand ? 1'($urandom_range(0, 1)) : 1'b1; end
  end

  // Monitor: every handshake pops its expectation.
  initial begin
    bit prev_ar_wait, prev_fin; logic [31:0] prev_addr; logic [7:0] prev_len;
    ar_t a, e; beat_t b; fin_t f;
    prev_ar_wait = 0; prev_fin = 0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ar_wait = 0; prev_fin = 0;
      end else begin
        if (prev_ar_wait) check("ar_held_stable", {arvalid, araddr, arlen}, {1'b1, prev_addr, prev_len});
        if (arvalid && first_ar_pending) begin
          check("accept_to_arvalid", cyc - acc_cyc, 2);
          first_ar_pending = 0;
        end
        if (arvalid && arready) begin
          a.addr = araddr; a.len = arlen; ar_log.push_back(a);
          check("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            e = exp_ar.pop_front();
            check("araddr", araddr, e.addr);
            check("arlen", arlen, e.len);
          end
        end
        prev_ar_wait = arvalid && !arready; prev_addr = araddr; prev_len = arlen;
        if (tvalid && tready) begin
          beat_cnt++;
          if (tlast) last_tlast_cyc = cyc;
          check("beat_expected", exp_beat.size() != 0, 1);
          if (exp_beat.size() != 0) begin
            b = exp_beat.pop_front();
            check("tdata", tdata, b.data);
            check("tlast", tlast, b.last);
            check("tuser", tuser, b.user);
          end
        end
        if (finish) begin
          check("finish_one_cycle", prev_fin, 0);
          check("finish_expected", exp_fin.size() != 0, 1);
          if (exp_fin.size() != 0) begin
            f = exp_fin.pop_front();
            if (f.zero) check("zero_req_finish_latency", cyc - f.acc, 2);
            else        check("last_beat_to_finish", cyc - last_tlast_cyc, 1);
            check("beats_left_at_finish", exp_beat.size(), 0);
            check("bursts_left_at_finish", exp_ar.size(), 0);
            check("rd_ptr_at_finish", rd_ptr, f.ptr);
          end
        end
        prev_fin = finish;
      end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n;
    flush_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", rd_ready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_finish", finish, 0);
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_err", rd_err, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("idle_ready", rd_ready, 1);
    @(posedge clk); #1;

    // q2, 256 B
    issue(2, 256, 1); wait_done(500);
    check("t1_beats", beat_cnt, 4);
    check("t1_bursts", ar_log.size(), 1);
    check("t1_araddr", ar_log[0].addr, 32'h0010_0000);
    check("t1_arlen", ar_log[0].len, 3);
    check("t1_ptr2", rd_ptr[2*AW +: AW], 256);

    // q0, 8 KB: two 4 KB bursts
    issue(0, 8192, 0); wait_done(2000);
    check("t2_beats", beat_cnt, 128);
    check("t2_bursts", ar_log.size(), 2);
    check("t2_addr0", ar_log[0].addr, 32'h0);
    check("t2_addr1", ar_log[1].addr, 32'h1000);
    check("t2_len0", ar_log[0].len, 63);
    check("t2_len1", ar_log[1].len, 63);

    // zero-length and non-multiple byte counts
    issue(5, 0, 1); wait_done(100);
    check("t4_zero_beats", beat_cnt, 0);
    check("t4_zero_bursts", ar_log.size(), 0);
    issue(5, 65, 0); wait_done(200);
    check("t4_65_beats", beat_cnt, 2);
    check("t4_65_arlen", ar_log[0].len, 1);

    // 32 beats with random downstream backpressure
    trdy_rand = 1;
    issue(6, 2048, 1); wait_done(1000);
    check("t5_beats", beat_cnt, 32);

    // push q1 to offset 0x7FFC0, then read across the region wrap
    trdy_rand = 0; slv_fast = 1;
    issue(1, 32'h7FFC0, 0); wait_done(20000);
    check("t3_prep_ptr", rd_ptr[1*AW +: AW], 32'h7FFC0);
    slv_fast = 0;
    issue(1, 128, 1); wait_done(500);
    check("t3_bursts", ar_log.size(), 2);
    check("t3_addr0", ar_log[0].addr, 32'h000F_FFC0);
    check("t3_len0", ar_log[0].len, 0);
    check("t3_addr1", ar_log[1].addr, 32'h0008_0000);
    check("t3_len1", ar_log[1].len, 0);
    check("t3_ptr1", rd_ptr[1*AW +: AW], 32'h40);

    // error response on beat 3
    err_addr = 32'(4 * QSIZE) + model_off[4] + 32'd128; err_en = 1;
    issue(4, 512, 1); wait_done(500);
    err_en = 0;
    check("err_beats", beat_cnt, 8);
    check("err_flag", rd_err, EXP_ERR);

    // random traffic, including out-of-range queue indices
    trdy_rand = 1;
    for (int t = 0; t < 25; t++) begin
      issue($urandom_range(0, 15), ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 3000)),
            1'($urandom_range(0, 1)));
      wait_done(3000);
    end
    check("err_sticky", rd_err, EXP_ERR);

    // reset in the middle of a burst
    trdy_rand = 0;
    issue(3, 1024, 1);
    n = 0;
    while (beat_cnt < 5 && n < 500) begin @(negedge clk); n++; end
    check("rst_test_progress", beat_cnt >= 5, 1);
    @(posedge clk); #1 rst = 1; flush_model();
    @(negedge clk); @(negedge clk);
    check("midrst_ready", rd_ready, 0);
    check("midrst_ar", {arvalid, araddr, arlen}, 0);
    check("midrst_r", {rready, tvalid, tlast, tuser}, 0);
    check("midrst_tdata", tdata, 0);
    check("midrst_finish", finish, 0);
    check("midrst_rd_ptr", rd_ptr, 0);
    check("midrst_err", rd_err, 0);
    @(posedge clk); #1 rst = 0;
    repeat (20) @(posedge clk);
    #1;
    issue(3, 128, 0); wait_done(500);
    check("post_rst_beats", beat_cnt, 2);
    check("post_rst_ptr3", rd_ptr[3*AW +: AW], 128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
